// File: rtl/axil_csr_pkg.sv
// rtl/axil_csr_pkg.sv - register offsets, status bit indices and response codes for axil_accel_csr
package axil_csr_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } axi_resp_t;

   typedef enum logic [2:0] {
      REG_CTRL,
      REG_STATUS,
      REG_VERSION,
      REG_CFG,
      REG_NONE
   } reg_sel_t;

   localparam logic [31:0] CTRL_OFF    = 32'h00;
   localparam logic [31:0] STATUS_OFF  = 32'h04;
   localparam logic [31:0] VERSION_OFF = 32'h08;
   localparam logic [31:0] CFG_OFF     = 32'h10;

   localparam int CTRL_START  = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int STATUS_DONE = 0;
   localparam int STATUS_BUSY = 1;
   localparam int STATUS_ERR  = 2;

   // word is the byte address with bits [1:0] already dropped
   function automatic reg_sel_t decode(input logic [31:0] word, input int unsigned num_cfg);
      reg_sel_t sel;
      if (word == (CTRL_OFF >> 2))
         sel = REG_CTRL;
      else if (word == (STATUS_OFF >> 2))
         sel = REG_STATUS;
      else if (word == (VERSION_OFF >> 2))
         sel = REG_VERSION;
      else if (word >= (CFG_OFF >> 2) && word < ((CFG_OFF >> 2) + num_cfg))
         sel = REG_CFG;
      else
         sel = REG_NONE;
      return sel;
   endfunction

endpackage

// File: rtl/axil_accel_csr_if.sv
// rtl/axil_accel_csr_if.sv - AXI-Lite bus bundle for axil_accel_csr
interface axil_accel_csr_if #(parameter int unsigned ADDR_W = 12);
   logic [ADDR_W-1:0] s_axi_awaddr;
   logic              s_axi_awvalid;
   logic              s_axi_awready;
   logic [31:0]       s_axi_wdata;
   logic [3:0]        s_axi_wstrb;
   logic              s_axi_wvalid;
   logic              s_axi_wready;
   logic              s_axi_bvalid;
   logic [1:0]        s_axi_bresp;
   logic              s_axi_bready;
   logic [ADDR_W-1:0] s_axi_araddr;
   logic              s_axi_arvalid;
   logic              s_axi_arready;
   logic [31:0]       s_axi_rdata;
   logic [1:0]        s_axi_rresp;
   logic              s_axi_rvalid;
   logic              s_axi_rready;

   modport slave (
      input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
             s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
             s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );

   modport master (
      output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
             s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
             s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );
endinterface

// File: rtl/axil_hold_slot.sv
// rtl/axil_hold_slot.sv - one-entry hold slot for an AXI-Lite AW or W beat
module axil_hold_slot #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         block,
   input  logic         clear,
   output logic         ready,
   output logic         held,
   output logic [W-1:0] data
);

   logic         held_q, held_d;
   logic [W-1:0] data_q, data_d;

   assign ready = !held_q && !block;
   assign held  = held_q;
   assign data  = data_q;

   always_comb begin
      held_d = held_q;
      data_d = data_q;
      if (clear) begin
         held_d = 1'b0;
      end else if (in_valid && ready) begin
         held_d = 1'b1;
         data_d = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_q <= 1'b0;
         data_q <= '0;
      end else begin
         held_q <= held_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/axil_accel_csr.sv
// rtl/axil_accel_csr.sv - AXI-Lite CSR block for an accelerator: CTRL/STATUS/VERSION/CFG, start/done/irq
// Optional CSR_IRQ_EN: implements CTRL.IRQ_EN and the irq output; otherwise irq is tied low.
module axil_accel_csr
   import axil_csr_pkg::*;
#(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned NUM_CFG = 4,
   parameter logic [31:0] VERSION = 32'h0001_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   axil_accel_csr_if.slave      axi,
   output logic [NUM_CFG*32-1:0] cfg,
   output logic                 start,
   input  logic                 done,
   output logic                 irq
);

   logic              aw_held, w_held, commit, b_hs, ar_hs, start_req, irq_en_rd;
   logic [ADDR_W-3:0] aw_addr;
   logic [35:0]       w_bits;
   logic [31:0]       wdata, aw_word, ar_word;
   logic [3:0]        wstrb;
   reg_sel_t          aw_sel;
   logic              unused_addr_lsbs;

   logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d, start_q, start_d;
   logic        done_q, done_d, busy_q, busy_d, err_q, err_d;
   axi_resp_t   bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] cfg_q [NUM_CFG];
   logic [31:0] cfg_d [NUM_CFG];

   axil_hold_slot #(.W(ADDR_W - 2)) u_aw_slot (
      .clk(clk), .rst_n(rst_n), .in_valid(axi.s_axi_awvalid),
      .in_data(axi.s_axi_awaddr[ADDR_W-1:2]), .block(bvalid_q), .clear(b_hs),
      .ready(axi.s_axi_awready), .held(aw_held), .data(aw_addr)
   );

   axil_hold_slot #(.W(36)) u_w_slot (
      .clk(clk), .rst_n(rst_n), .in_valid(axi.s_axi_wvalid),
      .in_data({axi.s_axi_wstrb, axi.s_axi_wdata}), .block(bvalid_q), .clear(b_hs),
      .ready(axi.s_axi_wready), .held(w_held), .data(w_bits)
   );

   assign unused_addr_lsbs = ^{axi.s_axi_awaddr[1:0], axi.s_axi_araddr[1:0]};
   assign {wstrb, wdata}   = w_bits;
   assign aw_word          = 32'(aw_addr);
   assign ar_word          = 32'(axi.s_axi_araddr[ADDR_W-1:2]);
   assign aw_sel           = decode(aw_word, NUM_CFG);
   assign commit           = aw_held && w_held && !bvalid_q;
   assign b_hs             = bvalid_q && axi.s_axi_bready;
   assign ar_hs            = axi.s_axi_arvalid && !rvalid_q;

   assign axi.s_axi_bvalid  = bvalid_q;
   assign axi.s_axi_bresp   = bresp_q;
   assign axi.s_axi_arready = !rvalid_q;
   assign axi.s_axi_rvalid  = rvalid_q;
   assign axi.s_axi_rdata   = rdata_q;
   assign axi.s_axi_rresp   = rresp_q;
   assign start             = start_q;

   always_comb begin
      for (int i = 0; i < NUM_CFG; i++) cfg[32*i +: 32] = cfg_q[i];
   end

   // W1C clears are applied before hardware sets so a same-cycle set wins
   always_comb begin
      cfg_d     = cfg_q;
      done_d    = done_q;
      busy_d    = busy_q;
      err_d     = err_q;
      start_d   = 1'b0;
      start_req = 1'b0;
      bvalid_d  = b_hs ? 1'b0 : bvalid_q;
      bresp_d   = bresp_q;
      if (commit) begin
         bvalid_d = 1'b1;
         bresp_d  = OKAY;
         case (aw_sel)
            REG_CTRL:   start_req = wstrb[0] && wdata[CTRL_START];
            REG_STATUS: begin
               if (wstrb[0] && wdata[STATUS_DONE]) done_d = 1'b0;
               if (wstrb[0] && wdata[STATUS_ERR])  err_d  = 1'b0;
            end
            REG_CFG: begin
               for (int i = 0; i < NUM_CFG; i++) begin
                  if (aw_word == ((CFG_OFF >> 2) + 32'(i))) begin
                     for (int b = 0; b < 4; b++)
                        if (wstrb[b]) cfg_d[i][8*b +: 8] = wdata[8*b +: 8];
                  end
               end
            end
            default:    bresp_d = SLVERR;
         endcase
      end
      if (done && busy_q) begin
         busy_d = 1'b0;
         done_d = 1'b1;
      end
      if (start_req) begin
         if (busy_q) begin
            err_d = 1'b1;
         end else begin
            start_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
         end
      end
   end

   always_comb begin
      rvalid_d = (rvalid_q && axi.s_axi_rready) ? 1'b0 : rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = OKAY;
         rdata_d  = '0;
         case (decode(ar_word, NUM_CFG))
            REG_CTRL:    rdata_d[CTRL_IRQ_EN] = irq_en_rd;
            REG_STATUS:  rdata_d[2:0] = {err_q, busy_q, done_q};
            REG_VERSION: rdata_d = VERSION;
            REG_CFG: begin
               for (int i = 0; i < NUM_CFG; i++)
                  if (ar_word == ((CFG_OFF >> 2) + 32'(i))) rdata_d = cfg_q[i];
            end
            default:     rresp_d = SLVERR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bvalid_q <= 1'b0;
         bresp_q  <= OKAY;
         rvalid_q <= 1'b0;
         rresp_q  <= OKAY;
         rdata_q  <= '0;
         start_q  <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         cfg_q    <= '{default: '0};
      end else begin
         bvalid_q <= bvalid_d;
         bresp_q  <= bresp_d;
         rvalid_q <= rvalid_d;
         rresp_q  <= rresp_d;
         rdata_q  <= rdata_d;
         start_q  <= start_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         cfg_q    <= cfg_d;
      end
   end

`ifdef CSR_IRQ_EN
   logic irq_en_q, irq_en_d;

   always_comb begin
      irq_en_d = irq_en_q;
      if (commit && aw_sel == REG_CTRL && wstrb[0]) irq_en_d = wdata[CTRL_IRQ_EN];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq_en_q <= 1'b0;
      else        irq_en_q <= irq_en_d;
   end

   assign irq_en_rd = irq_en_q;
   assign irq       = irq_en_q & (done_q | err_q);
`else
   assign irq_en_rd = 1'b0;
   assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_axil_accel_csr.sv
// tb/tb_axil_accel_csr.sv - directed self-checking bench for axil_accel_csr
module tb_axil_accel_csr;

`ifdef CSR_IRQ_EN
   localparam logic IRQ_IMPL = 1'b1;
`else
   localparam logic IRQ_IMPL = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         done = 1'b0;
   logic         start, irq;
   logic [127:0] cfg;
   int           n_checks = 0;
   int           n_pass = 0;
   int           start_cnt = 0;
   int           b_cnt = 0;

   axil_accel_csr_if #(.ADDR_W(12)) bus ();

   axil_accel_csr #(.ADDR_W(12), .NUM_CFG(4), .VERSION(32'h0001_0000)) dut (
      .clk(clk), .rst_n(rst_n), .axi(bus), .cfg(cfg), .start(start), .done(done), .irq(irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (start) start_cnt <= start_cnt + 1;
      if (bus.s_axi_bvalid && bus.s_axi_bready) b_cnt <= b_cnt + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      bit aw_pend = 1'b1, w_pend = 1'b1, aw_acc, w_acc, got = 1'b0;
      resp = 2'bxx;
      @(posedge clk); #1;
      bus.s_axi_awaddr = addr; bus.s_axi_awvalid = 1'b1;
      bus.s_axi_wdata = data; bus.s_axi_wstrb = strb; bus.s_axi_wvalid = 1'b1;
      for (int c = 0; c < 50 && (aw_pend || w_pend); c++) begin
         @(negedge clk);
         aw_acc = aw_pend && bus.s_axi_awready;
         w_acc  = w_pend && bus.s_axi_wready;
         @(posedge clk); #1;
         if (aw_acc) begin aw_pend = 1'b0; bus.s_axi_awvalid = 1'b0; end
         if (w_acc)  begin w_pend = 1'b0;  bus.s_axi_wvalid = 1'b0; end
      end
      bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
      bus.s_axi_bready = 1'b1;
      for (int c = 0; c < 50 && !got; c++) begin
         @(negedge clk);
         if (bus.s_axi_bvalid) begin resp = bus.s_axi_bresp; got = 1'b1; end
      end
      @(posedge clk); #1;
      bus.s_axi_bready = 1'b0;
      if (!got || aw_pend || w_pend) begin
         n_checks++;
         $display("FAIL write_timeout: addr %h got_b %0d aw_pend %0d w_pend %0d required b response", addr, got, aw_pend, w_pend);
      end
   endtask

   task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
      bit acc = 1'b0, got = 1'b0;
      data = 'x; resp = 2'bxx;
      @(posedge clk); #1;
      bus.s_axi_araddr = addr; bus.s_axi_arvalid = 1'b1;
      for (int c = 0; c < 50 && !acc; c++) begin
         @(negedge clk);
         acc = bus.s_axi_arready;
         @(posedge clk); #1;
      end
      bus.s_axi_arvalid = 1'b0;
      bus.s_axi_rready = 1'b1;
      for (int c = 0; c < 50 && !got; c++) begin
         @(negedge clk);
         if (bus.s_axi_rvalid) begin data = bus.s_axi_rdata; resp = bus.s_axi_rresp; got = 1'b1; end
      end
      @(posedge clk); #1;
      bus.s_axi_rready = 1'b0;
      if (!got) begin
         n_checks++;
         $display("FAIL read_timeout: addr %h accepted %0d required r response", addr, acc);
      end
   endtask

   task automatic pulse_done();
      @(posedge clk); #1 done = 1'b1;
      @(posedge clk); #1 done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (bus.s_axi_awready !== 1'b1) $display("FAIL rst_awready: got %b want 1", bus.s_axi_awready); else n_pass++;
      n_checks++; if (bus.s_axi_wready !== 1'b1) $display("FAIL rst_wready: got %b want 1", bus.s_axi_wready); else n_pass++;
      n_checks++; if (bus.s_axi_arready !== 1'b1) $display("FAIL rst_arready: got %b want 1", bus.s_axi_arready); else n_pass++;
      n_checks++; if (bus.s_axi_bvalid !== 1'b0) $display("FAIL rst_bvalid: got %b want 0", bus.s_axi_bvalid); else n_pass++;
      n_checks++; if (bus.s_axi_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", bus.s_axi_rvalid); else n_pass++;
      n_checks++; if (start !== 1'b0) $display("FAIL rst_start: got %b want 0", start); else n_pass++;
      n_checks++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq); else n_pass++;
      n_checks++; if (cfg !== 128'h0) $display("FAIL rst_cfg: got %h want 0", cfg); else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midflight();
      @(posedge clk); #1;
      bus.s_axi_awaddr = 12'h010; bus.s_axi_awvalid = 1'b1;
      @(posedge clk); #1;
      bus.s_axi_awvalid = 1'b0;
      n_checks++; if (bus.s_axi_awready !== 1'b0) $display("FAIL mid_aw_held: got awready %b want 0", bus.s_axi_awready); else n_pass++;
      rst_n = 1'b0;
      #2;
      n_checks++; if (bus.s_axi_awready !== 1'b1) $display("FAIL mid_async_clear: got awready %b want 1", bus.s_axi_awready); else n_pass++;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      bus.s_axi_wdata = 32'hFFFF_FFFF; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
      @(posedge clk); #1 bus.s_axi_wvalid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.s_axi_bvalid !== 1'b0) $display("FAIL mid_no_b: got bvalid %b want 0", bus.s_axi_bvalid); else n_pass++;
      n_checks++; if (cfg !== 128'h0) $display("FAIL mid_no_commit: got cfg %h want 0", cfg); else n_pass++;
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_version();
      logic [31:0] rd; logic [1:0] rr;
      axi_read(12'h008, rd, rr);
      n_checks++; if (rd !== 32'h0001_0000) $display("FAIL version_data: got %h want 00010000", rd); else n_pass++;
      n_checks++; if (rr !== 2'b00) $display("FAIL version_resp: got %b want 00", rr); else n_pass++;
   endtask

   task automatic test_cfg_strobes();
      logic [31:0] rd; logic [1:0] rr, br;
      axi_write(12'h014, 32'hDEAD_BEEF, 4'b0011, br);
      n_checks++; if (br !== 2'b00) $display("FAIL cfg1_bresp: got %b want 00", br); else n_pass++;
      axi_read(12'h014, rd, rr);
      n_checks++; if (rd !== 32'h0000_BEEF) $display("FAIL cfg1_strb_data: got %h want 0000beef", rd); else n_pass++;
      n_checks++; if (rr !== 2'b00) $display("FAIL cfg1_rresp: got %b want 00", rr); else n_pass++;
      axi_write(12'h01C, 32'h1234_5678, 4'b1100, br);
      n_checks++; if (br !== 2'b00) $display("FAIL cfg3_bresp: got %b want 00", br); else n_pass++;
      axi_read(12'h01F, rd, rr);
      n_checks++; if (rd !== 32'h1234_0000) $display("FAIL cfg3_lsb_ignored: got %h want 12340000", rd); else n_pass++;
      n_checks++; if (cfg[127:96] !== 32'h1234_0000) $display("FAIL cfg3_port: got %h want 12340000", cfg[127:96]); else n_pass++;
   endtask

   task automatic test_w_before_aw();
      logic [31:0] rd; logic [1:0] rr, br;
      int b0;
      bit got = 1'b0;
      b0 = b_cnt;
      @(posedge clk); #1;
      bus.s_axi_wdata = 32'hA5A5_0001; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.s_axi_wready !== 1'b1) $display("FAIL wfirst_wready: got %b want 1", bus.s_axi_wready); else n_pass++;
      @(posedge clk); #1 bus.s_axi_wvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++; if (bus.s_axi_wready !== 1'b0) $display("FAIL wfirst_wready_low: cycle %0d got %b want 0", c, bus.s_axi_wready); else n_pass++;
         n_checks++; if (bus.s_axi_bvalid !== 1'b0) $display("FAIL wfirst_no_b: cycle %0d got %b want 0", c, bus.s_axi_bvalid); else n_pass++;
      end
      @(posedge clk); #1;
      bus.s_axi_awaddr = 12'h010; bus.s_axi_awvalid = 1'b1;
      @(posedge clk); #1 bus.s_axi_awvalid = 1'b0;
      bus.s_axi_bready = 1'b1;
      br = 2'bxx;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (bus.s_axi_bvalid) begin br = bus.s_axi_bresp; got = 1'b1; end
      end
      @(posedge clk); #1 bus.s_axi_bready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (!got || br !== 2'b00) $display("FAIL wfirst_bresp: got %b (seen %0d) want 00", br, got); else n_pass++;
      n_checks++; if (b_cnt - b0 !== 1) $display("FAIL wfirst_b_count: got %0d want 1", b_cnt - b0); else n_pass++;
      axi_read(12'h010, rd, rr);
      n_checks++; if (rd !== 32'hA5A5_0001) $display("FAIL wfirst_data: got %h want a5a50001", rd); else n_pass++;
   endtask

   task automatic test_start_done();
      logic [31:0] rd; logic [1:0] rr, br;
      int s0;
      s0 = start_cnt;
      axi_write(12'h000, 32'h1, 4'hF, br);
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (start_cnt - s0 !== 1) $display("FAIL start_pulse_count: got %0d want 1", start_cnt - s0); else n_pass++;
      axi_read(12'h004, rd, rr);
      n_checks++; if (rd !== 32'h2) $display("FAIL status_busy: got %h want 2", rd); else n_pass++;
      pulse_done();
      axi_read(12'h004, rd, rr);
      n_checks++; if (rd !== 32'h1) $display("FAIL status_done: got %h want 1", rd); else n_pass++;
      axi_write(12'h004, 32'h1, 4'hF, br);
      axi_read(12'h004, rd, rr);
      n_checks++; if (rd !== 32'h0) $display("FAIL status_w1c: got %h want 0", rd); else n_pass++;
      pulse_done();
      axi_read(12'h004, rd, rr);
      n_checks++; if (rd !== 32'h0) $display("FAIL done_when_idle: got %h want 0", rd); else n_pass++;
   endtask

   task automatic test_start_busy();
      logic [31:0] rd; logic [1:0] rr, br;
      int s0;
      s0 = start_cnt;
      axi_write(12'h000, 32'h3, 4'hF, br);
      n_checks++; if (start_cnt - s0 !== 1) $display("FAIL busy_first_start: got %0d want 1", start_cnt - s0); else n_pass++;
      n_checks++; if (irq !== 1'b0) $display("FAIL irq_while_busy: got %b want 0", irq); else n_pass++;
      axi_write(12'h000, 32'h3, 4'hF, br);
      n_checks++; if (br !== 2'b00) $display("FAIL busy_start_bresp: got %b want 00", br); else n_pass++;
      n_checks++; if (start_cnt - s0 !== 1) $display("FAIL busy_no_start: got %0d want 1", start_cnt - s0); else n_pass++;
      axi_read(12'h004, rd, rr);
      n_checks++; if (rd !== 32'h6) $display("FAIL status_err: got %h want 6", rd); else n_pass++;
      n_checks++; if (irq !== IRQ_IMPL) $display("FAIL irq_err: got %b want %b", irq, IRQ_IMPL); else n_pass++;
      axi_read(12'h000, rd, rr);
      n_checks++; if (rd !== {30'b0, IRQ_IMPL, 1'b0}) $display("FAIL ctrl_read: got %h want %h", rd, {30'b0, IRQ_IMPL, 1'b0}); else n_pass++;
      pulse_done();
      axi_read(12'h004, rd, rr);
      n_checks++; if (rd !== 32'h5) $display("FAIL status_done_err: got %h want 5", rd); else n_pass++;
      axi_write(12'h004, 32'h5, 4'hF, br);
      axi_read(12'h004, rd, rr);
      n_checks++; if (rd !== 32'h0) $display("FAIL status_clear_all: got %h want 0", rd); else n_pass++;
      n_checks++; if (irq !== 1'b0) $display("FAIL irq_cleared: got %b want 0", irq); else n_pass++;
   endtask

   task automatic test_set_wins();
      logic [31:0] rd; logic [1:0] rr, br;
      bit got = 1'b0;
      axi_write(12'h000, 32'h1, 4'hF, br);
      @(posedge clk); #1;
      bus.s_axi_awaddr = 12'h004; bus.s_axi_awvalid = 1'b1;
      bus.s_axi_wdata = 32'h1; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
      @(negedge clk);
      n_checks++; if ((bus.s_axi_awready & bus.s_axi_wready) !== 1'b1) $display("FAIL setwins_ready: got %b%b want 11", bus.s_axi_awready, bus.s_axi_wready); else n_pass++;
      @(posedge clk); #1;
      bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; done = 1'b1;
      @(posedge clk); #1 done = 1'b0;
      bus.s_axi_bready = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if (bus.s_axi_bvalid) got = 1'b1;
      end
      @(posedge clk); #1 bus.s_axi_bready = 1'b0;
      n_checks++; if (!got) $display("FAIL setwins_b: got no response want one"); else n_pass++;
      axi_read(12'h004, rd, rr);
      n_checks++; if (rd !== 32'h1) $display("FAIL setwins_done: got %h want 1", rd); else n_pass++;
      axi_write(12'h004, 32'h1, 4'hF, br);
   endtask

   task automatic test_slverr();
      logic [31:0] rd; logic [1:0] rr, br;
      axi_write(12'h008, 32'hFFFF_FFFF, 4'hF, br);
      n_checks++; if (br !== 2'b10) $display("FAIL version_wr_bresp: got %b want 10", br); else n_pass++;
      axi_read(12'h008, rd, rr);
      n_checks++; if (rd !== 32'h0001_0000) $display("FAIL version_unchanged: got %h want 00010000", rd); else n_pass++;
      axi_write(12'h040, 32'hFFFF_FFFF, 4'hF, br);
      n_checks++; if (br !== 2'b10) $display("FAIL unmapped_bresp: got %b want 10", br); else n_pass++;
      axi_read(12'h040, rd, rr);
      n_checks++; if (rr !== 2'b10) $display("FAIL unmapped_rresp: got %b want 10", rr); else n_pass++;
      n_checks++; if (rd !== 32'h0) $display("FAIL unmapped_rdata: got %h want 0", rd); else n_pass++;
      axi_write(12'h020, 32'hFFFF_FFFF, 4'hF, br);
      n_checks++; if (br !== 2'b10) $display("FAIL cfg_past_end_bresp: got %b want 10", br); else n_pass++;
      n_checks++; if (cfg !== 128'h1234_0000_0000_0000_0000_BEEF_A5A5_0001) $display("FAIL cfg_unchanged: got %h want 12340000000000000000beefa5a50001", cfg); else n_pass++;
      axi_read(12'h004, rd, rr);
      n_checks++; if (rd !== 32'h0) $display("FAIL status_unchanged: got %h want 0", rd); else n_pass++;
   endtask

   initial begin
      bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0;
      bus.s_axi_bready = 1'b0;
      bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
      test_reset();
      test_reset_midflight();
      test_version();
      test_cfg_strobes();
      test_w_before_aw();
      test_start_done();
      test_start_busy();
      test_set_wins();
      test_slverr();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
